// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP16 opcode enum, constants and helpers for the FPU scheduler
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MULT = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4,
    OP_ABS  = 3'd5,
    OP_MIN  = 3'd6,
    OP_CONV = 3'd7
  } fpu_operations_t;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic        UNIT_ADD  = 1'b0;
  localparam logic        UNIT_MUL  = 1'b1;

  function automatic logic is_nan16(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// rtl/fpu_sync_fifo.sv - synchronous FIFO with registered full/empty and occupancy count
module fpu_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && !empty;
  // A pop frees the slot that a simultaneous push lands in, so full does not block it.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
        empty <= 1'b0;
        full  <= (count == CW'(DEPTH - 1));
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
        full  <= 1'b0;
        empty <= (count == CW'(1));
      end
    end
  end

endmodule

// File: rtl/fpu_op_scheduler.sv
// rtl/fpu_op_scheduler.sv - in-order, credit-gated command scheduler for the shared FP16 add/mult pipelines
module fpu_op_scheduler
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        add_vin,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic        add_vout,
  input  logic [15:0] add_res,
  output logic        mul_vin,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic        mul_vout,
  input  logic [15:0] mul_res,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_err,
  input  logic        irq_en,
  output logic        irq,
  output logic        busy
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [34:0]     cmd_head;
  logic            cmd_full, cmd_empty;
  logic [CW-1:0]   cmd_count;
  logic [16:0]     res_head;
  logic [16:0]     res_push_data;
  logic            res_full, res_empty, res_push;
  logic [CW-1:0]   res_count;
  logic [CW-1:0]   inflight;
  logic            unit;
  logic [CW:0]     credit_sum;

  fpu_operations_t h_op;
  logic [15:0]     h_a, h_b, local_res, min_res;
  logic            is_add_op, is_mul_op, is_local_op, local_err;
  logic            hazard, credit_ok, issue, add_issue, mul_issue, local_issue;
  logic            add_ret, mul_ret;

  fpu_sync_fifo #(.WIDTH(35), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk(clk), .rst(rst),
    .push(cmd_valid && cmd_ready), .push_data({cmd_op, cmd_a, cmd_b}),
    .pop(issue), .pop_data(cmd_head),
    .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
  );

  fpu_sync_fifo #(.WIDTH(17), .DEPTH(DEPTH)) u_res_fifo (
    .clk(clk), .rst(rst),
    .push(res_push), .push_data(res_push_data),
    .pop(res_ready), .pop_data(res_head),
    .full(res_full), .empty(res_empty), .count(res_count)
  );

  assign h_op = fpu_operations_t'(cmd_head[34:32]);
  assign h_a  = cmd_head[31:16];
  assign h_b  = cmd_head[15:0];

  always_comb begin
    is_add_op   = (h_op == OP_ADD) || (h_op == OP_SUB);
    is_mul_op   = (h_op == OP_MULT);
    is_local_op = !is_add_op && !is_mul_op;
  end

  // In-flight ops all belong to one pipeline; anything else waits so results stay in command order.
  assign hazard     = (inflight != '0) &&
                      (is_local_op || (is_add_op && unit == UNIT_MUL) || (is_mul_op && unit == UNIT_ADD));
  assign credit_sum = {1'b0, res_count} + {1'b0, inflight};
  assign credit_ok  = !res_full && (credit_sum < DEPTH_W);
  assign issue      = !cmd_empty && credit_ok && !hazard;
  assign add_issue  = issue && is_add_op;
  assign mul_issue  = issue && is_mul_op;
  assign local_issue = issue && is_local_op;

  assign add_vin = add_issue;
  assign add_a   = add_issue ? h_a : '0;
  assign add_b   = add_issue ? ((h_op == OP_SUB) ? {~h_b[15], h_b[14:0]} : h_b) : '0;
  assign mul_vin = mul_issue;
  assign mul_a   = mul_issue ? h_a : '0;
  assign mul_b   = mul_issue ? h_b : '0;

  // Sign-magnitude minimum; +0 and -0 compare equal and keep a.
  always_comb begin
    min_res = h_a;
    if (is_nan16(h_a) || is_nan16(h_b)) begin
      min_res = FP16_QNAN;
    end else if (h_a[14:0] == 15'd0 && h_b[14:0] == 15'd0) begin
      min_res = h_a;
    end else if (h_a[15] != h_b[15]) begin
      min_res = h_a[15] ? h_a : h_b;
    end else if (!h_a[15]) begin
      min_res = (h_b[14:0] < h_a[14:0]) ? h_b : h_a;
    end else begin
      min_res = (h_b[14:0] > h_a[14:0]) ? h_b : h_a;
    end
  end

  always_comb begin
    local_res = FP16_QNAN;
    local_err = 1'b0;
    case (h_op)
      OP_ABS:                    local_res = {1'b0, h_a[14:0]};
      OP_MIN:                    local_res = min_res;
      OP_DIV, OP_SQRT, OP_CONV:  local_err = 1'b1;
      default:                   local_err = 1'b0;
    endcase
  end

  assign add_ret       = add_vout && (inflight != '0) && (unit == UNIT_ADD);
  assign mul_ret       = mul_vout && (inflight != '0) && (unit == UNIT_MUL);
  assign res_push      = local_issue || add_ret || mul_ret;
  assign res_push_data = local_issue ? {local_err, local_res}
                                     : {1'b0, (add_ret ? add_res : mul_res)};

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      unit     <= UNIT_ADD;
    end else begin
      if ((add_issue || mul_issue) && !(add_ret || mul_ret)) begin
        inflight <= inflight + 1'b1;
      end else if (!(add_issue || mul_issue) && (add_ret || mul_ret)) begin
        inflight <= inflight - 1'b1;
      end
      if (add_issue) begin
        unit <= UNIT_ADD;
      end else if (mul_issue) begin
        unit <= UNIT_MUL;
      end
    end
  end

  assign cmd_ready = !cmd_full;
  assign res_valid = !res_empty;
  assign res_data  = res_valid ? res_head[15:0] : '0;
  assign res_err   = res_valid ? res_head[16] : 1'b0;
  assign irq       = res_valid && irq_en;
  assign busy      = (cmd_count != '0) || !res_empty || (inflight != '0);

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// tb/tb_fpu_op_scheduler.sv - self-checking bench for fpu_op_scheduler with modelled add/mult pipelines
module tb_fpu_op_scheduler;
  import fpu_pkg::*;

  localparam int ADD_L = 5;
  localparam int MUL_L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        add_vin, add_vout, mul_vin, mul_vout;
  logic [15:0] add_a, add_b, add_res, mul_a, mul_b, mul_res;
  logic        res_valid, res_ready, res_err, irq_en, irq, busy;
  logic [15:0] res_data;

  typedef struct {
    int          due;
    logic [15:0] res;
  } unit_op_t;

  unit_op_t    add_q[$];
  unit_op_t    mul_q[$];
  logic [16:0] exp_q[$];
  logic [16:0] popped[$];
  int          pop_cyc[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_pops = 0;
  int add_vin_cnt = 0;
  int add_vout_cyc = -1;
  int mul_vin_cyc = -1;
  int mul_vout_cyc = -1;
  int acc_cyc = 0;

  logic [15:0] btab [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                            16'h4500, 16'h4600, 16'h4700, 16'h4800};

  fpu_op_scheduler #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .add_vin(add_vin), .add_a(add_a), .add_b(add_b), .add_vout(add_vout), .add_res(add_res),
    .mul_vin(mul_vin), .mul_a(mul_a), .mul_b(mul_b), .mul_vout(mul_vout), .mul_res(mul_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .irq_en(irq_en), .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) m = real'(h[9:0]) * pow2(-24);
    else        m = (1024.0 + real'(h[9:0])) * pow2(e - 25);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  m;
    int   e;
    int   man;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    man = int'((m - 1.0) * 1024.0);
    return {s, e[4:0], man[9:0]};
  endfunction

  function automatic logic nan_h(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

  // Expected {err, data} of one command, straight from the operation's arithmetic meaning.
  function automatic logic [16:0] exp_of(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return {1'b0, r2h(h2r(a) + h2r(b))};
      3'd1: return {1'b0, r2h(h2r(a) - h2r(b))};
      3'd2: return {1'b0, r2h(h2r(a) * h2r(b))};
      3'd5: return {1'b0, r2h((h2r(a) < 0.0) ? -h2r(a) : h2r(a))};
      3'd6: begin
        if (nan_h(a) || nan_h(b)) return {1'b0, 16'h7E00};
        return {1'b0, (h2r(a) <= h2r(b)) ? a : b};
      end
      default: return {1'b1, 16'h7E00};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout at cycle %0d", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(negedge clk);
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) timeout_fail("send");
    acc_cyc = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pops(input int target);
    int guard = 0;
    while (n_pops < target && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (n_pops < target) timeout_fail("wait_pops");
    step();
  endtask

  // Pipeline responders plus the per-cycle scoreboard.
  initial begin : monitor
    logic [16:0] e;
    add_vout = 1'b0; mul_vout = 1'b0; add_res = '0; mul_res = '0;
    forever begin
      step();
      cyc++;
      add_vout = 1'b0;
      mul_vout = 1'b0;
      if (add_q.size() > 0 && add_q[0].due == cyc) begin
        add_vout = 1'b1; add_res = add_q[0].res; add_vout_cyc = cyc;
        void'(add_q.pop_front());
      end
      if (mul_q.size() > 0 && mul_q[0].due == cyc) begin
        mul_vout = 1'b1; mul_res = mul_q[0].res; mul_vout_cyc = cyc;
        void'(mul_q.pop_front());
      end
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() == 0) chk("no_pending_res_valid", res_valid, 0);
        if (cmd_valid && cmd_ready) exp_q.push_back(exp_of(cmd_op, cmd_a, cmd_b));
        if (res_valid && res_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("res_data", res_data, e[15:0]);
          chk("res_err", res_err, e[16]);
          popped.push_back({res_err, res_data});
          pop_cyc.push_back(cyc);
          n_pops++;
        end
        if (add_vin) chk("add_issue_with_mul_inflight", mul_q.size(), 0);
        if (mul_vin) chk("mul_issue_with_add_inflight", add_q.size(), 0);
      end
      if (!irq_en) chk("irq_masked", irq, 0);
      if (add_vin) begin
        add_q.push_back('{cyc + ADD_L, r2h(h2r(add_a) + h2r(add_b))});
        add_vin_cnt++;
      end
      if (mul_vin) begin
        mul_q.push_back('{cyc + MUL_L, r2h(h2r(mul_a) * h2r(mul_b))});
        mul_vin_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0, base, v0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    res_ready = 1'b1; irq_en = 1'b1;

    chk("model_add_pin", r2h(h2r(16'h3C00) + h2r(16'h4000)), 16'h4200);
    chk("model_min_zero_pin", exp_of(3'd6, 16'h8000, 16'h0000), {1'b0, 16'h8000});
    chk("model_abs_pin", exp_of(3'd5, 16'hC500, 16'h0000), {1'b0, 16'h4500});

    @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_add_vin", add_vin, 0);
    chk("rst_mul_vin", mul_vin, 0);
    chk("rst_add_ops", {add_a, add_b}, 0);
    chk("rst_mul_ops", {mul_a, mul_b}, 0);
    chk("rst_irq", irq, 0);
    chk("rst_busy", busy, 0);
    step();
    rst = 1'b0;

    // ADD latency
    send(OP_ADD, 16'h3C00, 16'h4000);
    t0 = acc_cyc;
    @(negedge clk);
    chk("add_vin_cycle1", add_vin, 1);
    chk("add_ops_cycle1", {add_a, add_b}, {16'h3C00, 16'h4000});
    wait_to(t0 + 1 + ADD_L);
    chk("add_res_not_yet", res_valid, 0);
    wait_to(t0 + 2 + ADD_L);
    chk("add_res_valid", res_valid, 1);
    chk("add_res_data", res_data, 16'h4200);
    chk("add_res_err", res_err, 0);
    step();

    // SUB flips the sign of b
    base = n_pops;
    send(OP_SUB, 16'h4000, 16'h3C00);
    @(negedge clk);
    chk("sub_add_vin", add_vin, 1);
    chk("sub_add_b", add_b, 16'hBC00);
    step();
    wait_pops(base + 1);
    chk("sub_result", popped[base], {1'b0, 16'h3C00});

    // ADD, MULT, ABS ordering across unit switches
    base = n_pops;
    send(OP_ADD, 16'h3C00, 16'h3C00);
    send(OP_MULT, 16'h4000, 16'h4200);
    send(OP_ABS, 16'hC500, 16'h0000);
    wait_pops(base + 3);
    chk("mul_waits_for_add", mul_vin_cyc, add_vout_cyc + 1);
    chk("abs_waits_for_mul", pop_cyc[base + 2], mul_vout_cyc + 2);
    chk("seq_pop0", popped[base], {1'b0, 16'h4000});
    chk("seq_pop1", popped[base + 1], {1'b0, 16'h4600});
    chk("seq_pop2", popped[base + 2], {1'b0, 16'h4500});

    // MIN / DIV error flags and ordering
    base = n_pops;
    send(OP_MIN, 16'hC000, 16'h3C00);
    send(OP_MIN, 16'h7E01, 16'h0000);
    send(OP_DIV, 16'h3C00, 16'h4000);
    send(OP_MIN, 16'h8000, 16'h0000);
    wait_pops(base + 4);
    chk("min_neg", popped[base], {1'b0, 16'hC000});
    chk("min_nan", popped[base + 1], {1'b0, 16'h7E00});
    chk("div_err", popped[base + 2], {1'b1, 16'h7E00});
    chk("min_zeros", popped[base + 3], {1'b0, 16'h8000});

    // Credit gating with the consumer stalled
    res_ready = 1'b0;
    base = n_pops;
    v0 = add_vin_cnt;
    for (int k = 0; k < 8; k++) send(OP_ADD, 16'h3C00, btab[k]);
    repeat (12) @(negedge clk);
    chk("credit_issued", add_vin_cnt - v0, 4);
    chk("credit_cmd_ready", cmd_ready, 0);
    chk("credit_res_valid", res_valid, 1);
    chk("credit_irq", irq, 1);
    chk("credit_busy", busy, 1);
    irq_en = 1'b0;
    #1;
    chk("irq_off", irq, 0);
    irq_en = 1'b1;
    #1;
    chk("irq_on", irq, 1);
    step();
    res_ready = 1'b1;
    wait_pops(base + 8);
    chk("drain_first", popped[base], {1'b0, 16'h4000});
    chk("drain_last", popped[base + 7], {1'b0, 16'h4880});

    // Reset with two ADDs in flight and two MULTs queued
    send(OP_ADD, 16'h3C00, 16'h3C00);
    t0 = acc_cyc;
    send(OP_ADD, 16'h4000, 16'h4000);
    send(OP_MULT, 16'h4000, 16'h4000);
    send(OP_MULT, 16'h4000, 16'h4000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("late_vout_ignored", res_valid, 0);
    end
    chk("late_vout_seen", (add_vout_cyc >= t0 + 1 + ADD_L), 1);
    step();

    // Recovery after reset
    base = n_pops;
    send(OP_ADD, 16'h4400, 16'h4400);
    wait_pops(base + 1);
    chk("post_rst_add", popped[base], {1'b0, 16'h4800});
    repeat (3) @(negedge clk);
    chk("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
